// File: rtl/booth_mul_seq_pkg.sv
// Shared widths, step count and FSM encoding for the sequential radix-4 Booth multiplier.
package booth_mul_seq_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int STEPS  = 4;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiplier bit triplet {b[2k+1], b[2k], b[2k-1]} for step k, with b[-1] = 0.
  function automatic logic [2:0] boothTriplet(input logic [OP_W-1:0] b,
                                              input logic [STEP_W-1:0] step);
    logic [OP_W:0] bExt;
    bExt = {b, 1'b0};
    return bExt[{step, 1'b0} +: 3];
  endfunction

endpackage

// File: rtl/booth_mul_seq_enc.sv
// Radix-4 Booth partial-product encoder: selects 0, +-a or +-2a as a 9-bit
// one's-complement value plus a separate +1 correction bit for negatives.
module booth_radix4_enc
  import booth_mul_seq_pkg::*;
(
  input  logic [2:0]      triplet_i,
  input  logic [OP_W-1:0] data_i,
  output logic [OP_W:0]   pp_o,
  output logic            neg_o
);

  logic [OP_W:0] magnitude;

  always_comb begin
    magnitude = '0;
    case (triplet_i)
      3'b000, 3'b111: magnitude = '0;
      3'b011, 3'b100: magnitude = {data_i, 1'b0};
      default:        magnitude = {data_i[OP_W-1], data_i};
    endcase
    // Negative selections are inverted here; the +1 is folded in by the accumulator.
    neg_o = triplet_i[2] & ~(triplet_i[1] & triplet_i[0]);
    pp_o  = magnitude ^ {(OP_W + 1){neg_o}};
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential 8x8 signed multiplier: one shared radix-4 Booth encoder,
// four accumulate steps, valid/ready handshakes on both sides.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PROD_W-1:0] res_o,
  output logic              busy_o
);

  state_e              state_q;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_d;
  logic [STEP_W-1:0]   step_q;
  logic                ready_q;
  logic                valid_q;
  logic                busy_q;

  logic [2:0]          encTriplet;
  logic [OP_W:0]       encPp;
  logic                encNeg;
  logic [PROD_W-1:0]   partial;

  assign encTriplet = boothTriplet(b_q, step_q);

  booth_radix4_enc u_enc (
    .triplet_i (encTriplet),
    .data_i    (a_q),
    .pp_o      (encPp),
    .neg_o     (encNeg)
  );

  // Sign-extend the encoder output, add the negation correction, weight by 4^k.
  always_comb begin
    partial = {{(PROD_W - OP_W - 1){encPp[OP_W]}}, encPp}
            + {{(PROD_W - 1){1'b0}}, encNeg};
    acc_d   = acc_q + (partial << {step_q, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            a_q     <= a_i;
            b_q     <= b_i;
            acc_q   <= '0;
            step_q  <= '0;
            state_q <= BUSY;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          acc_q  <= acc_d;
          step_q <= step_q + 1'b1;
          if (step_q == STEP_W'(STEPS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign res_o   = acc_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, abort/stall
// sequences and randomized operands scored against signed integer multiplication.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        ready_o;
  logic        valid_o;
  logic        busy_o;
  logic [15:0] res_o;

  int checks = 0;
  int fails = 0;
  int txCount = 0;
  int handshakes = 0;
  logic [15:0] expQ[$];
  logic [15:0] monExp;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          readyEarly;
    int          stall;
  } vec_t;

  vec_t vecs[10];

  booth_mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = sa * sb;
    return p[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted request must produce exactly one matching result.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
    end else begin
      if (valid_o && ready_i) begin
        handshakes++;
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unrequested result: got %0h expected no result", res_o);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("scoreboard product", 32'(res_o), 32'(monExp));
        end
      end
      if (valid_i && ready_o)
        expQ.push_back(refProduct(a_i, b_i));
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                               input bit readyEarly, input int stall);
    int waitCnt;
    int latency;
    waitCnt = 0;
    while (!ready_o && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("ready before request", 32'(ready_o), 32'd1);
    a_i = a;
    b_i = b;
    valid_i = 1'b1;
    ready_i = readyEarly;
    @(posedge clk); #1;
    valid_i = 1'($urandom);
    a_i = 8'($urandom);
    b_i = 8'($urandom);
    checkOutput("busy after accept", 32'({busy_o, ready_o, valid_o}), 32'b100);
    latency = 0;
    do begin
      @(posedge clk); #1;
      latency++;
      if (!valid_o) begin
        valid_i = 1'($urandom);
        a_i = 8'($urandom);
        b_i = 8'($urandom);
      end
    end while (!valid_o && latency < 20);
    valid_i = 1'b0;
    checkOutput("latency", 32'(latency), 32'd4);
    checkOutput("product", 32'(res_o), 32'(exp));
    if (!readyEarly) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        a_i = 8'($urandom);
        b_i = 8'($urandom);
        checkOutput("held valid", 32'(valid_o), 32'd1);
        checkOutput("held product", 32'(res_o), 32'(exp));
      end
      ready_i = 1'b1;
    end
    @(posedge clk); #1;
    ready_i = 1'b0;
    checkOutput("idle after handshake", 32'({ready_o, valid_o, busy_o}), 32'b100);
    txCount++;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h03, 8'h05, 16'h000F, 1'b1, 0};
    vecs[1] = '{8'h80, 8'h80, 16'h4000, 1'b1, 0};
    vecs[2] = '{8'h80, 8'h7F, 16'hC080, 1'b0, 2};
    vecs[3] = '{8'hFF, 8'hFF, 16'h0001, 1'b1, 0};
    vecs[4] = '{8'h5A, 8'h00, 16'h0000, 1'b1, 0};
    vecs[5] = '{8'h00, 8'h5A, 16'h0000, 1'b0, 1};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01, 1'b1, 0};
    vecs[7] = '{8'h80, 8'h01, 16'hFF80, 1'b0, 0};
    vecs[8] = '{8'h07, 8'hFD, 16'hFFEB, 1'b0, 10};
    vecs[9] = '{8'hAB, 8'h55, 16'hE3C7, 1'b1, 0};

    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset ready_o", 32'(ready_o), 32'd1);
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset res_o", 32'(res_o), 32'd0);

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].readyEarly, vecs[i].stall);

    // Abort in the middle of accumulation; no result may ever appear for it.
    a_i = 8'h55;
    b_i = 8'h33;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("idle after abort", 32'({ready_o, valid_o, busy_o}), 32'b100);
    checkOutput("res after abort", 32'(res_o), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no result after abort", 32'({valid_o, busy_o}), 32'b00);
    ready_i = 1'b0;
    applyStimulus(8'h02, 8'h02, 16'h0004, 1'b1, 0);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, refProduct(ra, rb), 1'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("handshake count", 32'(handshakes), 32'(txCount));
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
